// File: rtl/cpu_pkg.sv
// Shared CPU-model types: opcode encodings, pre-decoded immediate info and
// the decode-buffer entry layout.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef struct packed {
    logic [15:0] imm;
    logic        sext;
    logic        has_imm;
    logic        illegal;
  } dec_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    dec_t        dec;
  } entry_t;

endpackage

// File: rtl/id_predecode.sv
// Combinational opcode pre-decode: classifies the immediate (signed,
// unsigned or absent) and flags opcodes outside the supported set.
module id_predecode
  import cpu_pkg::*;
(
  input  logic [31:0] instr_i,
  output dec_t        dec_o
);

  logic [5:0] opcode;
  assign opcode = instr_i[31:26];

  always_comb begin
    dec_o.imm     = instr_i[15:0];
    dec_o.sext    = 1'b0;
    dec_o.has_imm = 1'b0;
    dec_o.illegal = 1'b0;
    case (opcode)
      OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: begin
        dec_o.sext    = 1'b1;
        dec_o.has_imm = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        dec_o.has_imm = 1'b1;
      end
      OP_RTYPE, OP_J, OP_JAL: begin
        dec_o.has_imm = 1'b0;
      end
      default: begin
        dec_o.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/id_stage_buf.sv
// Decode-stage input buffer: 2-entry skid buffer (main drives the outputs)
// holding instructions that were pre-decoded on the way in.
module id_stage_buf
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [15:0] out_imm,
  output logic        out_sext,
  output logic        out_has_imm,
  output logic        out_illegal
);

  // Handshake: a word moves on a side only in a cycle where that side's
  // valid and ready are both high; valid never depends on ready, and
  // in_ready is a flop (!skid valid), never a path from out_ready.

  // Empty slots hold a clean payload so the outputs are plain flop outputs.
  localparam entry_t EMPTY_E = '{valid: 1'b0, instr: 32'h0, pc: RESET_PC, dec: '0};

  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t in_e;
  dec_t   in_dec;
  logic   acc;
  logic   pop;

  id_predecode u_predecode (
    .instr_i (in_instr),
    .dec_o   (in_dec)
  );

  assign in_e = '{valid: 1'b1, instr: in_instr, pc: in_pc, dec: in_dec};
  assign acc  = in_valid && in_ready;
  assign pop  = main_q.valid && out_ready;

  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (flush) begin
      main_d = EMPTY_E;
      skid_d = EMPTY_E;
    end else if (!main_q.valid || pop) begin
      if (skid_q.valid) begin
        main_d = skid_q;
        skid_d = acc ? in_e : EMPTY_E;
      end else begin
        main_d = acc ? in_e : EMPTY_E;
      end
    end else if (acc) begin
      skid_d = in_e;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= EMPTY_E;
      skid_q <= EMPTY_E;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  assign in_ready    = !skid_q.valid;
  assign out_valid   = main_q.valid;
  assign out_instr   = main_q.instr;
  assign out_pc      = main_q.pc;
  assign out_imm     = main_q.dec.imm;
  assign out_sext    = main_q.dec.sext;
  assign out_has_imm = main_q.dec.has_imm;
  assign out_illegal = main_q.dec.illegal;

endmodule

// File: tb/tb_id_stage_buf.sv
// Directed and randomised checks of the decode-stage skid buffer.
module tb_id_stage_buf;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [15:0] out_imm;
  logic        out_sext;
  logic        out_has_imm;
  logic        out_illegal;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q[$];

  typedef struct {
    logic [31:0] instr;
    logic [15:0] imm;
    logic        sext;
    logic        has_imm;
    logic        illegal;
  } vec_t;

  vec_t vecs[15];

  id_stage_buf dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .out_imm     (out_imm),
    .out_sext    (out_sext),
    .out_has_imm (out_has_imm),
    .out_illegal (out_illegal)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic rdy);
    in_valid  = v;
    in_instr  = instr;
    in_pc     = pc;
    out_ready = rdy;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, ".valid"},   out_valid,   1'b0);
    chk({tag, ".pc"},      out_pc,      32'h0);
    chk({tag, ".instr"},   out_instr,   32'h0);
    chk({tag, ".imm"},     out_imm,     16'h0);
    chk({tag, ".sext"},    out_sext,    1'b0);
    chk({tag, ".has_imm"}, out_has_imm, 1'b0);
    chk({tag, ".illegal"}, out_illegal, 1'b0);
  endtask

  initial begin
    logic        iv;
    logic        rdy;
    logic        acc;
    logic        pop;
    logic [31:0] seq;
    logic [31:0] rnd;

    vecs[0]  = '{32'h2008FFFF, 16'hFFFF, 1'b1, 1'b1, 1'b0}; // ADDI
    vecs[1]  = '{32'h3508FFFF, 16'hFFFF, 1'b0, 1'b1, 1'b0}; // ORI
    vecs[2]  = '{32'h012A4020, 16'h4020, 1'b0, 1'b0, 1'b0}; // ADD
    vecs[3]  = '{32'hFC000000, 16'h0000, 1'b0, 1'b0, 1'b1}; // op 0x3F
    vecs[4]  = '{32'h3C018000, 16'h8000, 1'b0, 1'b1, 1'b0}; // LUI
    vecs[5]  = '{32'h10000005, 16'h0005, 1'b1, 1'b1, 1'b0}; // BEQ
    vecs[6]  = '{32'h08000010, 16'h0010, 1'b0, 1'b0, 1'b0}; // J
    vecs[7]  = '{32'h04000000, 16'h0000, 1'b0, 1'b0, 1'b1}; // op 0x01
    vecs[8]  = '{32'h8C22FFFC, 16'hFFFC, 1'b1, 1'b1, 1'b0}; // LW
    vecs[9]  = '{32'hAC22FFFC, 16'hFFFC, 1'b1, 1'b1, 1'b0}; // SW
    vecs[10] = '{32'h2C010003, 16'h0003, 1'b1, 1'b1, 1'b0}; // SLTIU
    vecs[11] = '{32'h3001ABCD, 16'hABCD, 1'b0, 1'b1, 1'b0}; // ANDI
    vecs[12] = '{32'h0C000001, 16'h0001, 1'b0, 1'b0, 1'b0}; // JAL
    vecs[13] = '{32'h9C001234, 16'h1234, 1'b0, 1'b0, 1'b1}; // op 0x27
    vecs[14] = '{32'h94000000, 16'h0000, 1'b1, 1'b1, 1'b0}; // LHU

    rst_n = 1'b0;
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    step();
    step();
    chk_empty("reset");
    chk("reset.in_ready", in_ready, 1'b1);
    rst_n = 1'b1;

    // decode table, streamed back to back
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, vecs[i].instr, 32'h100 + 32'(i * 4), 1'b1);
      step();
      chk($sformatf("dec%0d.valid", i),   out_valid,   1'b1);
      chk($sformatf("dec%0d.instr", i),   out_instr,   vecs[i].instr);
      chk($sformatf("dec%0d.pc", i),      out_pc,      32'h100 + 32'(i * 4));
      chk($sformatf("dec%0d.imm", i),     out_imm,     vecs[i].imm);
      chk($sformatf("dec%0d.sext", i),    out_sext,    vecs[i].sext);
      chk($sformatf("dec%0d.has_imm", i), out_has_imm, vecs[i].has_imm);
      chk($sformatf("dec%0d.illegal", i), out_illegal, vecs[i].illegal);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    step();
    chk_empty("drained");

    // back-pressure stream of PCs 0x0..0xC
    drive(1'b1, 32'h20000000, 32'h0, 1'b1);
    step();
    chk("bp0.pc", out_pc, 32'h0);
    drive(1'b1, 32'h20000004, 32'h4, 1'b0);
    step();
    chk("bp1.pc", out_pc, 32'h0);
    chk("bp1.in_ready", in_ready, 1'b0);
    drive(1'b1, 32'h20000008, 32'h8, 1'b0);
    step();
    chk("bp2.pc", out_pc, 32'h0);
    chk("bp2.in_ready", in_ready, 1'b0);
    out_ready = 1'b1;
    step();
    chk("bp3.pc", out_pc, 32'h4);
    chk("bp3.in_ready", in_ready, 1'b1);
    step();
    chk("bp4.pc", out_pc, 32'h8);
    chk("bp4.valid", out_valid, 1'b1);
    drive(1'b1, 32'h2000000C, 32'hC, 1'b1);
    step();
    chk("bp5.pc", out_pc, 32'hC);
    chk("bp5.valid", out_valid, 1'b1);
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    step();
    chk("bp6.valid", out_valid, 1'b0);

    // flush with both entries full, then flush dropping an accepted word
    drive(1'b1, 32'h20000010, 32'h10, 1'b0);
    step();
    in_pc = 32'h14;
    step();
    chk("full.in_ready", in_ready, 1'b0);
    chk("full.pc", out_pc, 32'h10);
    flush = 1'b1;
    in_pc = 32'h18;
    step();
    chk("flush1.valid", out_valid, 1'b0);
    chk("flush1.in_ready", in_ready, 1'b1);
    chk("flush1.pc", out_pc, 32'h0);
    drive(1'b1, 32'h20000020, 32'h20, 1'b1);
    step();
    chk("flush2.valid", out_valid, 1'b0);
    flush = 1'b0;
    drive(1'b1, 32'h20000024, 32'h24, 1'b1);
    step();
    chk("flush3.pc", out_pc, 32'h24);
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    step();
    chk("flush4.valid", out_valid, 1'b0);

    // asynchronous reset mid-stream
    drive(1'b1, 32'h20000030, 32'h30, 1'b0);
    step();
    in_pc = 32'h34;
    step();
    chk("pre_rst.valid", out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.valid", out_valid, 1'b0);
    chk("arst.in_ready", in_ready, 1'b1);
    chk("arst.pc", out_pc, 32'h0);
    #2;
    rst_n = 1'b1;
    drive(1'b1, 32'h20000040, 32'h40, 1'b1);
    step();
    chk("post_rst.pc", out_pc, 32'h40);
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    step();
    chk("post_rst.empty", out_valid, 1'b0);

    // random valid/ready stress against the scoreboard queue
    seq = 32'h0;
    for (int c = 0; c < 10000; c++) begin
      iv  = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      rnd = $urandom;
      drive(iv, rnd, 32'h1000 + (seq << 2), rdy);
      acc = iv && (exp_q.size() < 2);
      pop = rdy && (exp_q.size() > 0);
      if (pop) begin
        chk("stress.head", {out_instr, out_pc}, exp_q[0]);
        void'(exp_q.pop_front());
      end
      if (acc) begin
        exp_q.push_back({rnd, 32'h1000 + (seq << 2)});
        seq++;
      end
      step();
      chk("stress.valid", out_valid, 64'(exp_q.size() > 0));
      chk("stress.in_ready", in_ready, 64'(exp_q.size() < 2));
    end

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
